// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its two client ports (CPU and
// serial loader/debug) and the synchronous RAM.
interface ram_arbiter_if #(
  parameter int AW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [7:0]    cpu_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_done;
  logic [7:0]    dbg_rdata;

  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_we;
  logic [7:0]    ram_rdata;

  // Client/RAM side: issues requests, supplies RAM read data.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single synchronous RAM with
// configurable read latency. One transaction at a time: IDLE -> ACCESS ->
// (WAIT x READ_LAT for reads) -> DONE -> IDLE.
module ram_arbiter #(
  parameter int READ_LAT = 1,
  parameter int AW       = 8
) (
  input  logic         clk50,
  input  logic         resetin,
  ram_arbiter_if.slave bus
);

  // A latency of 0 is treated as 1.
  localparam int LAT = (READ_LAT < 1) ? 1 : READ_LAT;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  typedef enum logic {PORT_CPU, PORT_DBG} port_t;

  state_t        state, state_next;
  port_t         owner, last_win, winner;
  logic          any_req;
  logic          we_q;
  logic [1:0]    wait_cnt;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    cpu_rdata_q;
  logic [7:0]    dbg_rdata_q;

  // Round-robin pick: on a tie the port that did not win last goes first.
  always_comb begin
    any_req = bus.cpu_req | bus.dbg_req;
    winner  = PORT_CPU;
    if (bus.cpu_req && bus.dbg_req)
      winner = (last_win == PORT_CPU) ? PORT_DBG : PORT_CPU;
    else if (bus.dbg_req)
      winner = PORT_DBG;
  end

  // State register.
  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = we_q ? DONE : WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant capture, RAM address/data registers, wait counter and read capture.
  // ram_addr/ram_wdata are loaded at grant so they are already valid during
  // ACCESS, and simply hold afterwards.
  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      owner       <= PORT_CPU;
      last_win    <= PORT_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner    <= winner;
        last_win <= winner;
        if (winner == PORT_CPU) begin
          we_q    <= bus.cpu_we;
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
        end else begin
          we_q    <= bus.dbg_we;
          addr_q  <= bus.dbg_addr;
          wdata_q <= bus.dbg_wdata;
        end
      end

      if (state == ACCESS)
        wait_cnt <= 2'(LAT - 1);
      else if (state == WAIT && wait_cnt != 2'd0)
        wait_cnt <= wait_cnt - 2'd1;

      if (state == WAIT && wait_cnt == 2'd0) begin
        if (owner == PORT_CPU) cpu_rdata_q <= bus.ram_rdata;
        else                   dbg_rdata_q <= bus.ram_rdata;
      end
    end
  end

  // Outputs decoded from state and owner.
  always_comb begin
    bus.cpu_gnt  = 1'b0;
    bus.dbg_gnt  = 1'b0;
    bus.cpu_done = 1'b0;
    bus.dbg_done = 1'b0;
    bus.ram_we   = 1'b0;
    if (state != IDLE) begin
      bus.cpu_gnt = (owner == PORT_CPU);
      bus.dbg_gnt = (owner == PORT_DBG);
    end
    if (state == DONE) begin
      bus.cpu_done = (owner == PORT_CPU);
      bus.dbg_done = (owner == PORT_DBG);
    end
    if (state == ACCESS)
      bus.ram_we = we_q;
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with READ_LAT=2.
module tb_ram_arbiter;

  localparam int RL = 2;

  logic clk50 = 1'b0;
  logic resetin;
  always #5 clk50 = ~clk50;

  ram_arbiter_if #(.AW(8)) bus();

  ram_arbiter #(.READ_LAT(RL), .AW(8)) dut (
    .clk50   (clk50),
    .resetin (resetin),
    .bus     (bus.slave)
  );

  // ---------------- RAM model (environment) ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] pipe [RL];
  always @(posedge clk50) begin
    pipe[0] <= ram_mem[bus.ram_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
  end
  assign bus.ram_rdata = pipe[RL-1];

  // ---------------- Reference model and scoreboard ----------------
  typedef struct {
    int         port;
    bit         we;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [256];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  logic       req_c_s = 1'b0;
  logic       req_d_s = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk50) begin
    cyc     <= cyc + 1;
    req_c_s <= bus.cpu_req;
    req_d_s <= bus.dbg_req;
  end

  function automatic logic gnt_of(input int p);
    return (p == 0) ? bus.cpu_gnt : bus.dbg_gnt;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? bus.cpu_done : bus.dbg_done;
  endfunction

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      bus.cpu_req = r; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = d;
    end else begin
      bus.dbg_req = r; bus.dbg_we = w; bus.dbg_addr = a; bus.dbg_wdata = d;
    end
  endtask

  // One client: n transactions with random gaps, random rewrites of
  // we/addr/wdata after grant and random early release of req.
  task automatic run_port(input int p, input int n, input int max_gap);
    for (int k = 0; k < n; k++) begin
      int         gap;
      int         w;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wd;
      exp_t       e;
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gap) @(negedge clk50);
      we   = 1'($urandom_range(0, 1));
      addr = 8'($urandom);
      wd   = 8'($urandom);
      drive(p, 1'b1, we, addr, wd);
      w = 0;
      do begin
        @(negedge clk50);
        w++;
      end while (!gnt_of(p) && w < 60);
      if (!gnt_of(p)) begin
        chk("gnt_timeout", 0, 1);
        drive(p, 1'b0, we, addr, wd);
        return;
      end
      // ACCESS cycle
      chk("access_ram_we", bus.ram_we, we);
      chk("access_ram_addr", bus.ram_addr, addr);
      if (we) chk("access_ram_wdata", bus.ram_wdata, wd);
      e.port = p;
      e.we   = we;
      e.data = we ? 8'h00 : ref_mem[addr];
      e.cyc  = cyc + (we ? 1 : 1 + RL);
      sb.push_back(e);
      if (we) ref_mem[addr] = wd;
      drive(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom));
      w = 0;
      do begin
        @(negedge clk50);
        w++;
        if (w == 1) chk("ram_we_off", bus.ram_we, 0);
      end while (!done_of(p) && w < 12);
      if (!done_of(p)) chk("done_timeout", 0, 1);
      drive(p, 1'b0, we, addr, wd);
    end
  endtask

  // ---------------- Monitor ----------------
  logic [7:0] hold_c   = 8'h00;
  logic [7:0] hold_d   = 8'h00;
  int         last_win = 1;
  logic       prev_c   = 1'b0;
  logic       prev_d   = 1'b0;

  always @(negedge clk50) begin
    if (!resetin) begin
      hold_c   = 8'h00;
      hold_d   = 8'h00;
      last_win = 1;
      prev_c   = 1'b0;
      prev_d   = 1'b0;
    end else begin
      int   w;
      int   exp_w;
      int   p;
      exp_t e;
      chk("one_gnt", bus.cpu_gnt & bus.dbg_gnt, 0);
      chk("one_done", bus.cpu_done & bus.dbg_done, 0);
      if ((bus.cpu_gnt && !prev_c) || (bus.dbg_gnt && !prev_d)) begin
        w = bus.dbg_gnt ? 1 : 0;
        if (req_c_s && req_d_s) exp_w = (last_win == 0) ? 1 : 0;
        else if (req_c_s)       exp_w = 0;
        else if (req_d_s)       exp_w = 1;
        else                    exp_w = 2;
        chk("rr_winner", w, exp_w);
        chk("idle_gap", prev_c | prev_d, 0);
        last_win = w;
      end
      if (bus.cpu_done || bus.dbg_done) begin
        p = bus.dbg_done ? 1 : 0;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_port", p, e.port);
          chk("done_cycle", cyc, e.cyc);
          if (!e.we) begin
            if (p == 0) hold_c = e.data;
            else        hold_d = e.data;
          end
        end
      end
      chk("cpu_rdata", bus.cpu_rdata, hold_c);
      chk("dbg_rdata", bus.dbg_rdata, hold_d);
      prev_c = bus.cpu_gnt;
      prev_d = bus.dbg_gnt;
    end
  end

  function automatic logic [63:0] out_vec();
    return {27'b0, bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done, bus.ram_we,
            bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.dbg_rdata};
  endfunction

  // ---------------- Main sequence ----------------
  initial begin
    int w;
    bit seen;
    resetin = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    #1 chk("reset_outputs", out_vec(), 0);
    repeat (3) @(negedge clk50);
    resetin = 1'b1;

    // Random traffic with gaps, then both ports requesting continuously.
    fork
      run_port(0, 80, 3);
      run_port(1, 80, 3);
    join
    fork
      run_port(0, 20, 0);
      run_port(1, 20, 0);
    join
    repeat (5) @(negedge clk50);

    // Reset pulse in the middle of a debug read.
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    w = 0;
    do begin
      @(negedge clk50);
      w++;
    end while (!bus.dbg_gnt && w < 20);
    chk("rst_dbg_gnt", bus.dbg_gnt, 1);
    @(negedge clk50);
    #2 resetin = 1'b0;
    #1 chk("async_reset_outputs", out_vec(), 0);
    drive(1, 1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk50);
    @(negedge clk50);
    #2 resetin = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk50);
      if (bus.dbg_done || bus.cpu_done) seen = 1'b1;
    end
    chk("no_done_after_reset", seen, 0);

    // First tie after reset goes to the CPU.
    fork
      run_port(0, 1, 0);
      run_port(1, 1, 0);
      begin
        int t;
        t = 0;
        do begin
          @(negedge clk50);
          t++;
        end while (!bus.cpu_gnt && !bus.dbg_gnt && t < 20);
        chk("first_tie_cpu", {bus.cpu_gnt, bus.dbg_gnt}, 2'b10);
      end
    join
    repeat (5) @(negedge clk50);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
